// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: state encoding, frame constants and bit-timing helper shared by the UART blocks
package uart_rx_pkg;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
    localparam int DATA_BITS = 8;
    localparam logic LINE_IDLE = 1'b1;
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for an asynchronous input, resets to the idle-high level
module uart_sync2
    import uart_rx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta, r_sync;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= LINE_IDLE;
            r_sync <= LINE_IDLE;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end
    assign o_q = r_sync;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: mid-bit sampling UART receiver, 8 data bits LSB first, optional parity, one stop bit
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_complete,
    output logic                 rx_error,
    output logic                 rx_busy
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_HALF = TW'(HALF - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
    state_t               r_state;
    logic [TW-1:0]        r_timer;
    logic [IW-1:0]        r_idx;
    logic [DATA_BITS-1:0] r_shift, r_data;
    logic                 r_perr, r_complete, r_error;
    logic                 w_rxs, w_tick;
    uart_sync2 u_sync (.clk(clk), .rst(rst), .i_d(rxd), .o_q(w_rxs));
    assign w_tick = r_timer == '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_perr     <= 1'b0;
            r_complete <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_complete <= 1'b0;
            r_error    <= 1'b0;
            r_timer    <= w_tick ? T_FULL : r_timer - 1'b1;
            case (r_state)
                S_IDLE: if (!w_rxs) begin
                    r_timer <= T_HALF;
                    r_state <= S_START;
                end
                S_START: if (w_tick) begin
                    r_idx   <= '0;
                    r_perr  <= 1'b0;
                    r_state <= w_rxs ? S_IDLE : S_DATA;
                end
                S_DATA: if (w_tick) begin
                    r_shift[r_idx] <= w_rxs;
                    r_idx          <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
                S_PARITY: if (w_tick) begin
                    r_perr  <= ((^r_shift) ^ w_rxs) != (PARITY_ODD != 0);
                    r_state <= S_STOP;
                end
                // Returning to IDLE at mid-stop leaves half a bit to catch a zero-gap start bit
                S_STOP: if (w_tick) begin
                    r_complete <= w_rxs && !r_perr;
                    r_error    <= !w_rxs || r_perr;
                    if (w_rxs && !r_perr) r_data <= r_shift;
                    r_state    <= w_rxs ? S_IDLE : S_BREAK;
                end
                S_BREAK: if (w_rxs) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign rx_data     = r_data;
    assign rx_complete = r_complete;
    assign rx_error    = r_error;
    assign rx_busy     = r_state != S_IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: frame-level model of expected pulses and held data checked every cycle, plus directed literals
module tb_uart_rx;
    logic clk = 1'b0, rst = 1'b1, rxd0 = 1'b1, rxd1 = 1'b1;
    logic [7:0] rx_data0, rx_data1;
    logic c0, e0, b0, c1, e1, b1;
    int vectors = 0, miscompares = 0, cyc = 0, t_fall = 0, last_c0 = 0, prev_c0 = 0;
    int n_c[2] = '{0, 0};
    int n_e[2] = '{0, 0};
    logic [7:0] md[2] = '{8'h00, 8'h00};
    typedef struct packed {logic err; logic [7:0] d;} ev_t;
    ev_t q0[$], q1[$];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    uart_rx #(.CLK_HZ(1_000_000), .BAUD(100_000)) dut (
        .clk(clk), .rst(rst), .rxd(rxd0), .rx_data(rx_data0),
        .rx_complete(c0), .rx_error(e0), .rx_busy(b0));
    uart_rx #(.CLK_HZ(1_000_000), .BAUD(100_000), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
        .clk(clk), .rst(rst), .rxd(rxd1), .rx_data(rx_data1),
        .rx_complete(c1), .rx_error(e1), .rx_busy(b1));
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    // Outcome of one frame from its bits alone: bad stop or bad even parity is an error
    function automatic ev_t predict(input logic [7:0] d, input logic pen, input logic pbit, input logic stop);
        ev_t r;
        r.err = !stop || (pen && ((^d) ^ pbit));
        r.d = d;
        return r;
    endfunction
    task automatic observe(input int id, input logic c, input logic er, input logic [7:0] d,
                           input logic have, input ev_t e, output logic pop);
        pop = 1'b0;
        chk($sformatf("exclusive_pulses%0d", id), 32'(c & er), 32'd0);
        if (c || er) begin
            if (c) n_c[id]++;
            else n_e[id]++;
            chk($sformatf("pulse_expected%0d", id), 32'(have), 32'd1);
            if (have) begin
                pop = 1'b1;
                chk($sformatf("pulse_kind%0d", id), 32'(er), 32'(e.err));
                if (c && !e.err) md[id] = e.d;
            end
        end
        chk($sformatf("rx_data%0d", id), 32'(d), 32'(md[id]));
    endtask
    always @(posedge clk) begin
        logic p;
        ev_t h0, h1;
        #2;
        if (rst) begin
            md = '{8'h00, 8'h00};
        end else begin
            h0 = q0.size() != 0 ? q0[0] : '0;
            h1 = q1.size() != 0 ? q1[0] : '0;
            observe(0, c0, e0, rx_data0, q0.size() != 0, h0, p);
            if (p) void'(q0.pop_front());
            if (c0) begin
                prev_c0 = last_c0;
                last_c0 = cyc;
            end
            observe(1, c1, e1, rx_data1, q1.size() != 0, h1, p);
            if (p) void'(q1.pop_front());
        end
    end
    task automatic line(input int id, input logic v);
        if (id == 0) rxd0 = v;
        else rxd1 = v;
    endtask
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask
    // rst_bit >= 0 pulses reset for one clock in the middle of that frame bit (0 = start bit)
    task automatic send(input int id, input logic [7:0] d, input logic pen, input logic pbit,
                        input logic stop, input int stop_len, input logic expect_ev, input int rst_bit);
        logic [10:0] bits;
        int n;
        n = pen ? 11 : 10;
        bits = pen ? {stop, pbit, d, 1'b0} : {1'b0, stop, d, 1'b0};
        if (expect_ev) begin
            if (id == 0) q0.push_back(predict(d, pen, pbit, stop));
            else q1.push_back(predict(d, pen, pbit, stop));
        end
        t_fall = cyc;
        for (int k = 0; k < n; k++) begin
            line(id, bits[k]);
            for (int j = 0; j < ((k == n - 1) ? stop_len : 10); j++) begin
                rst = (k == rst_bit) && (j == 5);
                if (k == rst_bit && j == 6) begin
                    chk("mid_reset_data", 32'(rx_data0), 32'h00);
                    chk("mid_reset_busy", 32'(b0), 32'd0);
                    chk("mid_reset_pulses", 32'(c0 | e0), 32'd0);
                end
                @(negedge clk);
            end
        end
        rst = 1'b0;
    endtask
    initial begin
        int lat;
        idle(3);
        rst = 1'b0;
        idle(1);
        chk("reset_data", 32'(rx_data0), 32'h00);
        chk("reset_complete", 32'(c0), 32'd0);
        chk("reset_error", 32'(e0), 32'd0);
        chk("reset_busy", 32'(b0 | b1), 32'd0);
        send(0, 8'hA5, 1'b0, 1'b0, 1'b1, 10, 1'b1, -1);
        idle(20);
        lat = last_c0 - t_fall;
        chk("latency_a5", 32'((lat >= 97 && lat <= 99) ? 98 : lat), 32'd98);
        chk("data_a5", 32'(rx_data0), 32'hA5);
        chk("busy_after_a5", 32'(b0), 32'd0);
        send(0, 8'h3C, 1'b0, 1'b0, 1'b0, 30, 1'b1, -1);
        chk("break_busy", 32'(b0), 32'd1);
        line(0, 1'b1);
        idle(6);
        chk("break_release", 32'(b0), 32'd0);
        chk("break_keeps_data", 32'(rx_data0), 32'hA5);
        chk("break_error_count", 32'(n_e[0]), 32'd1);
        idle(20);
        send(0, 8'h01, 1'b0, 1'b0, 1'b1, 10, 1'b1, -1);
        idle(20);
        chk("data_01", 32'(rx_data0), 32'h01);
        line(0, 1'b0);
        idle(3);
        chk("false_start_busy", 32'(b0), 32'd1);
        line(0, 1'b1);
        idle(6);
        chk("false_start_drop", 32'(b0), 32'd0);
        idle(20);
        send(0, 8'h5A, 1'b0, 1'b0, 1'b1, 10, 1'b1, -1);
        idle(20);
        chk("data_5a", 32'(rx_data0), 32'h5A);
        send(0, 8'h00, 1'b0, 1'b0, 1'b1, 10, 1'b1, -1);
        chk("b2b_first", 32'(rx_data0), 32'h00);
        send(0, 8'hFF, 1'b0, 1'b0, 1'b1, 10, 1'b1, -1);
        idle(20);
        chk("b2b_second", 32'(rx_data0), 32'hFF);
        lat = last_c0 - prev_c0;
        chk("b2b_spacing", 32'((lat >= 99 && lat <= 101) ? 100 : lat), 32'd100);
        send(1, 8'h07, 1'b1, 1'b1, 1'b1, 10, 1'b1, -1);
        idle(20);
        chk("parity_good", 32'(rx_data1), 32'h07);
        send(1, 8'h07, 1'b1, 1'b0, 1'b1, 10, 1'b1, -1);
        idle(20);
        chk("parity_bad_keeps", 32'(rx_data1), 32'h07);
        chk("parity_counts", 32'({n_c[1][15:0], n_e[1][15:0]}), 32'h0001_0001);
        send(0, 8'hF3, 1'b0, 1'b0, 1'b1, 10, 1'b0, 5);
        idle(20);
        chk("after_reset_data", 32'(rx_data0), 32'h00);
        chk("after_reset_count", 32'(n_c[0]), 32'd5);
        send(0, 8'hC3, 1'b0, 1'b0, 1'b1, 10, 1'b1, -1);
        idle(20);
        chk("data_c3", 32'(rx_data0), 32'hC3);
        chk("final_counts0", 32'({n_c[0][15:0], n_e[0][15:0]}), 32'h0006_0001);
        chk("pending_events", 32'(q0.size() + q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
